memory_port_arbiter: RTL and testbench

MEMORY_PORT_ARBITER -- requirements
Module: memory_port_arbiter

---
 rtl/memory_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_memory_port_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
// Two-master arbiter sharing one external memory port between instruction fetch and load/store.
// Optional fetch anti-starvation counter enabled by defining MEMORY_ARBITER_FAIRNESS_EN.
module memory_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_memoryAddress,
    input  logic        fetch_memoryReadEnable,
    output logic [31:0] fetch_memoryDataRead,
    output logic        fetch_memoryBusy,
    output logic        fetch_memoryAccessFault,
    output logic        fetch_addressBreakpoint,
    input  logic [31:0] data_memoryAddress,
    input  logic [3:0]  data_memoryByteSelect,
    input  logic        data_memoryWriteEnable,
    input  logic        data_memoryReadEnable,
    input  logic [31:0] data_memoryDataWrite,
    output logic [31:0] data_memoryDataRead,
    output logic        data_memoryBusy,
    output logic        data_memoryAccessFault,
    output logic        data_addressBreakpoint,
    output logic [31:0] external_memoryAddress,
    output logic [3:0]  external_memoryByteSelect,
    output logic        external_memoryWriteEnable,
    output logic        external_memoryReadEnable,
    output logic [31:0] external_memoryDataWrite,
    input  logic [31:0] external_memoryDataRead,
    input  logic        external_memoryBusy,
    input  logic        external_memoryAccessFault,
    input  logic        external_addressBreakpoint
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GRANT_FETCH = 2'd1,
        GRANT_DATA  = 2'd2
    } state_t;

    state_t state_r;
    state_t state_next_s;
    logic   fetch_req_s;
    logic   data_req_s;
    logic   fetch_wins_s;

    // The starvation counter is only 3 bits wide, so larger limits could never be reached.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_starve_limit
        $error("memory_port_arbiter: STARVE_LIMIT must be within 1..7");
    end

    assign fetch_req_s = fetch_memoryReadEnable;
    assign data_req_s  = data_memoryReadEnable | data_memoryWriteEnable;

    // Read data is shared; each master qualifies it with its own busy flag.
    assign fetch_memoryDataRead = external_memoryDataRead;
    assign data_memoryDataRead  = external_memoryDataRead;

`ifdef MEMORY_ARBITER_FAIRNESS_EN
    logic [2:0] starve_cnt_r;

    // Count data grants taken over a waiting fetch; saturates rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_r <= 3'd0;
        end else if (state_r == IDLE) begin
            if (!fetch_req_s || (state_next_s == GRANT_FETCH)) begin
                starve_cnt_r <= 3'd0;
            end else if ((state_next_s == GRANT_DATA) && (starve_cnt_r != 3'd7)) begin
                starve_cnt_r <= starve_cnt_r + 3'd1;
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    assign fetch_wins_s = fetch_req_s & (starve_cnt_r == 3'(STARVE_LIMIT));
`else
    assign fetch_wins_s = 1'b0;
`endif

    // State register; reset drops any in-flight transaction without completing it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state: arbitrate only in IDLE, leave a grant on completion or abort.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (data_req_s && !fetch_wins_s) begin
                    state_next_s = GRANT_DATA;
                end else if (fetch_req_s) begin
                    state_next_s = GRANT_FETCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GRANT_FETCH: begin
                if (fetch_req_s && external_memoryBusy) begin
                    state_next_s = GRANT_FETCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GRANT_DATA: begin
                if (data_req_s && external_memoryBusy) begin
                    state_next_s = GRANT_DATA;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Bus steering: the granted master sees the external bus, the other one stalls.
    always_comb begin
        external_memoryAddress     = 32'h0000_0000;
        external_memoryByteSelect  = 4'h0;
        external_memoryWriteEnable = 1'b0;
        external_memoryReadEnable  = 1'b0;
        external_memoryDataWrite   = 32'h0000_0000;
        fetch_memoryBusy           = fetch_req_s;
        fetch_memoryAccessFault    = 1'b0;
        fetch_addressBreakpoint    = 1'b0;
        data_memoryBusy            = data_req_s;
        data_memoryAccessFault     = 1'b0;
        data_addressBreakpoint     = 1'b0;
        case (state_r)
            GRANT_FETCH: begin
                external_memoryAddress    = fetch_memoryAddress;
                external_memoryByteSelect = 4'hF;
                external_memoryReadEnable = fetch_memoryReadEnable;
                fetch_memoryBusy          = external_memoryBusy;
                fetch_memoryAccessFault   = external_memoryAccessFault;
                fetch_addressBreakpoint   = external_addressBreakpoint;
            end
            GRANT_DATA: begin
                external_memoryAddress     = data_memoryAddress;
                external_memoryByteSelect  = data_memoryByteSelect;
                external_memoryWriteEnable = data_memoryWriteEnable;
                external_memoryReadEnable  = data_memoryReadEnable;
                external_memoryDataWrite   = data_memoryDataWrite;
                data_memoryBusy            = external_memoryBusy;
                data_memoryAccessFault     = external_memoryAccessFault;
                data_addressBreakpoint     = external_addressBreakpoint;
            end
            default: begin
                external_memoryAddress = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: expected external transactions are queued when
// requests are driven and popped when the arbiter presents them on the shared bus.
module tb_memory_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_memoryAddress;
    logic        fetch_memoryReadEnable;
    logic [31:0] fetch_memoryDataRead;
    logic        fetch_memoryBusy;
    logic        fetch_memoryAccessFault;
    logic        fetch_addressBreakpoint;
    logic [31:0] data_memoryAddress;
    logic [3:0]  data_memoryByteSelect;
    logic        data_memoryWriteEnable;
    logic        data_memoryReadEnable;
    logic [31:0] data_memoryDataWrite;
    logic [31:0] data_memoryDataRead;
    logic        data_memoryBusy;
    logic        data_memoryAccessFault;
    logic        data_addressBreakpoint;
    logic [31:0] external_memoryAddress;
    logic [3:0]  external_memoryByteSelect;
    logic        external_memoryWriteEnable;
    logic        external_memoryReadEnable;
    logic [31:0] external_memoryDataWrite;
    logic [31:0] external_memoryDataRead;
    logic        external_memoryBusy;
    logic        external_memoryAccessFault;
    logic        external_addressBreakpoint;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic        re;
        logic [31:0] wd;
    } ext_t;

    ext_t sb[$];
    ext_t held;
    int   n_tests = 0;
    int   n_fail  = 0;

    memory_port_arbiter dut (
        .clk                        (clk),
        .rst                        (rst),
        .fetch_memoryAddress        (fetch_memoryAddress),
        .fetch_memoryReadEnable     (fetch_memoryReadEnable),
        .fetch_memoryDataRead       (fetch_memoryDataRead),
        .fetch_memoryBusy           (fetch_memoryBusy),
        .fetch_memoryAccessFault    (fetch_memoryAccessFault),
        .fetch_addressBreakpoint    (fetch_addressBreakpoint),
        .data_memoryAddress         (data_memoryAddress),
        .data_memoryByteSelect      (data_memoryByteSelect),
        .data_memoryWriteEnable     (data_memoryWriteEnable),
        .data_memoryReadEnable      (data_memoryReadEnable),
        .data_memoryDataWrite       (data_memoryDataWrite),
        .data_memoryDataRead        (data_memoryDataRead),
        .data_memoryBusy            (data_memoryBusy),
        .data_memoryAccessFault     (data_memoryAccessFault),
        .data_addressBreakpoint     (data_addressBreakpoint),
        .external_memoryAddress     (external_memoryAddress),
        .external_memoryByteSelect  (external_memoryByteSelect),
        .external_memoryWriteEnable (external_memoryWriteEnable),
        .external_memoryReadEnable  (external_memoryReadEnable),
        .external_memoryDataWrite   (external_memoryDataWrite),
        .external_memoryDataRead    (external_memoryDataRead),
        .external_memoryBusy        (external_memoryBusy),
        .external_memoryAccessFault (external_memoryAccessFault),
        .external_addressBreakpoint (external_addressBreakpoint)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic ext_t ext_now();
        ext_t e;
        e.addr = external_memoryAddress;
        e.be   = external_memoryByteSelect;
        e.we   = external_memoryWriteEnable;
        e.re   = external_memoryReadEnable;
        e.wd   = external_memoryDataWrite;
        return e;
    endfunction

    task automatic expect_ext(input logic [31:0] addr, input logic [3:0] be,
                              input logic we, input logic re, input logic [31:0] wd);
        ext_t e;
        e.addr = addr;
        e.be   = be;
        e.we   = we;
        e.re   = re;
        e.wd   = wd;
        sb.push_back(e);
    endtask

    // Compare the bus against the last popped expectation (used while a grant is held).
    task automatic chk_held(input string tag);
        ext_t obs;
        obs = ext_now();
        n_tests++;
        assert (obs === held) else begin
            n_fail++;
            $error("FAIL %s: observed bus %h expected bus %h", tag, obs, held);
        end
    endtask

    task automatic chk_ext(input string tag);
        n_tests++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected a queued transaction", tag);
        end
        if (sb.size() > 0) begin
            held = sb.pop_front();
            chk_held(tag);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst                        = 1'b0;
        fetch_memoryAddress        = 32'h0;
        fetch_memoryReadEnable     = 1'b0;
        data_memoryAddress         = 32'h0;
        data_memoryByteSelect      = 4'h0;
        data_memoryWriteEnable     = 1'b0;
        data_memoryReadEnable      = 1'b0;
        data_memoryDataWrite       = 32'h0;
        external_memoryDataRead    = 32'h0;
        external_memoryBusy        = 1'b0;
        external_memoryAccessFault = 1'b0;
        external_addressBreakpoint = 1'b0;
        held                       = '0;

        // Reset state, with and without pending requests.
        step();
        step();
        chk1 ("rst_ext_re",   external_memoryReadEnable, 1'b0);
        chk1 ("rst_ext_we",   external_memoryWriteEnable, 1'b0);
        chk32("rst_ext_addr", external_memoryAddress, 32'h0);
        chk32("rst_ext_be",   {28'h0, external_memoryByteSelect}, 32'h0);
        chk1 ("rst_f_busy",   fetch_memoryBusy, 1'b0);
        fetch_memoryReadEnable = 1'b1;
        data_memoryWriteEnable = 1'b1;
        #1;
        chk1("rst_f_busy_req", fetch_memoryBusy, 1'b1);
        chk1("rst_d_busy_req", data_memoryBusy, 1'b1);
        step();
        chk1("rst_hold_re", external_memoryReadEnable, 1'b0);
        chk1("rst_hold_we", external_memoryWriteEnable, 1'b0);
        fetch_memoryReadEnable = 1'b0;
        data_memoryWriteEnable = 1'b0;
        #1;
        rst = 1'b1;
        step();

        // Fetch-only read, zero-wait memory.
        fetch_memoryAddress    = 32'h0000_0100;
        fetch_memoryReadEnable = 1'b1;
        expect_ext(32'h0000_0100, 4'hF, 1'b0, 1'b1, 32'h0);
        #1;
        chk1("f_req_busy_idle", fetch_memoryBusy, 1'b1);
        chk1("f_req_no_ext",    external_memoryReadEnable, 1'b0);
        step();
        external_memoryDataRead = 32'hCAFE_F00D;
        #1;
        chk_ext("f_grant_bus");
        chk1 ("f_grant_busy", fetch_memoryBusy, 1'b0);
        chk32("f_rdata",      fetch_memoryDataRead, 32'hCAFE_F00D);
        chk32("d_rdata",      data_memoryDataRead,  32'hCAFE_F00D);
        step();
        fetch_memoryReadEnable = 1'b0;
        #1;
        chk1("f_done_idle", external_memoryReadEnable, 1'b0);
        step();

        // Simultaneous requests: data first, fetch after one turnaround.
        data_memoryAddress     = 32'h0000_0200;
        data_memoryByteSelect  = 4'hF;
        data_memoryReadEnable  = 1'b1;
        data_memoryDataWrite   = 32'h1111_1111;
        fetch_memoryAddress    = 32'h0000_0300;
        fetch_memoryReadEnable = 1'b1;
        expect_ext(32'h0000_0200, 4'hF, 1'b0, 1'b1, 32'h1111_1111);
        expect_ext(32'h0000_0300, 4'hF, 1'b0, 1'b1, 32'h0);
        step();
        chk_ext("both_data_first");
        chk1("both_f_busy_g", fetch_memoryBusy, 1'b1);
        chk1("both_d_busy_g", data_memoryBusy, 1'b0);
        step();
        data_memoryReadEnable = 1'b0;
        #1;
        chk1("both_turn_f_busy", fetch_memoryBusy, 1'b1);
        chk1("both_turn_ext_re", external_memoryReadEnable, 1'b0);
        step();
        chk_ext("both_fetch_next");
        chk1("both_f_busy_done", fetch_memoryBusy, 1'b0);
        step();
        fetch_memoryReadEnable = 1'b0;
        step();

        // Data write held for three busy cycles.
        data_memoryAddress     = 32'h0000_0400;
        data_memoryByteSelect  = 4'b0011;
        data_memoryWriteEnable = 1'b1;
        data_memoryDataWrite   = 32'hDEAD_BEEF;
        external_memoryBusy    = 1'b1;
        expect_ext(32'h0000_0400, 4'b0011, 1'b1, 1'b0, 32'hDEAD_BEEF);
        step();
        chk_ext("wr_cycle1");
        chk1("wr_busy1", data_memoryBusy, 1'b1);
        step();
        chk_held("wr_cycle2");
        chk1("wr_busy2", data_memoryBusy, 1'b1);
        step();
        chk_held("wr_cycle3");
        chk1("wr_busy3", data_memoryBusy, 1'b1);
        step();
        external_memoryBusy = 1'b0;
        #1;
        chk_held("wr_cycle4");
        chk1("wr_busy4", data_memoryBusy, 1'b0);
        step();
        data_memoryWriteEnable = 1'b0;
        #1;
        chk1("wr_idle_we", external_memoryWriteEnable, 1'b0);
        step();

        // Fault routing in a data grant, then reset mid-transaction.
        data_memoryAddress         = 32'h0000_0500;
        data_memoryByteSelect      = 4'hF;
        data_memoryReadEnable      = 1'b1;
        data_memoryDataWrite       = 32'h0;
        fetch_memoryAddress        = 32'h0000_0580;
        fetch_memoryReadEnable     = 1'b1;
        external_memoryBusy        = 1'b1;
        external_memoryAccessFault = 1'b1;
        external_addressBreakpoint = 1'b1;
        expect_ext(32'h0000_0500, 4'hF, 1'b0, 1'b1, 32'h0);
        step();
        chk_ext("flt_grant_bus");
        chk1("flt_d_fault", data_memoryAccessFault, 1'b1);
        chk1("flt_d_bp",    data_addressBreakpoint, 1'b1);
        chk1("flt_f_fault", fetch_memoryAccessFault, 1'b0);
        chk1("flt_f_bp",    fetch_addressBreakpoint, 1'b0);
        rst = 1'b0;
        #1;
        chk1 ("mrst_ext_re",   external_memoryReadEnable, 1'b0);
        chk32("mrst_ext_addr", external_memoryAddress, 32'h0);
        chk1 ("mrst_d_busy",   data_memoryBusy, 1'b1);
        chk1 ("mrst_d_fault",  data_memoryAccessFault, 1'b0);
        chk1 ("mrst_f_busy",   fetch_memoryBusy, 1'b1);
        step();
        data_memoryReadEnable      = 1'b0;
        fetch_memoryReadEnable     = 1'b0;
        external_memoryAccessFault = 1'b0;
        external_addressBreakpoint = 1'b0;
        #1;
        rst = 1'b1;
        step();
        chk32("mrst_sb_empty", 32'(sb.size()), 32'd0);

        // Fetch abort while memory is busy; a data request is then granted from IDLE.
        fetch_memoryAddress    = 32'h0000_0900;
        fetch_memoryReadEnable = 1'b1;
        expect_ext(32'h0000_0900, 4'hF, 1'b0, 1'b1, 32'h0);
        step();
        chk_ext("abort_grant");
        chk1("abort_f_busy", fetch_memoryBusy, 1'b1);
        fetch_memoryReadEnable = 1'b0;
        #1;
        chk1("abort_ext_drop", external_memoryReadEnable, 1'b0);
        step();
        data_memoryAddress    = 32'h0000_0A00;
        data_memoryReadEnable = 1'b1;
        expect_ext(32'h0000_0A00, 4'hF, 1'b0, 1'b1, 32'h0);
        step();
        chk_ext("abort_then_data");
        external_memoryBusy = 1'b0;
        step();
        data_memoryReadEnable = 1'b0;
        step();

        // Both masters hold requests continuously: check the grant order.
        fetch_memoryAddress    = 32'h0000_0600;
        fetch_memoryReadEnable = 1'b1;
        data_memoryAddress     = 32'h0000_0700;
        data_memoryByteSelect  = 4'b0101;
        data_memoryReadEnable  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            int  k;
            logic exp_fetch;
`ifdef MEMORY_ARBITER_FAIRNESS_EN
            exp_fetch = ((i % 5) == 4);
`else
            exp_fetch = 1'b0;
`endif
            if (exp_fetch) begin
                expect_ext(32'h0000_0600, 4'hF, 1'b0, 1'b1, 32'h0);
            end else begin
                expect_ext(32'h0000_0700, 4'b0101, 1'b0, 1'b1, 32'h0);
            end
            k = 0;
            do begin
                step();
                k++;
            end while (!external_memoryReadEnable && (k < 4));
            chk1("order_grant_seen", external_memoryReadEnable, 1'b1);
            chk_ext("order_grant");
        end
        fetch_memoryReadEnable = 1'b0;
        data_memoryReadEnable  = 1'b0;
        step();
        step();
        chk32("end_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
